// File: rtl/radioberry_pkg.sv
// Shared TX IQ link types: word geometry, {I,Q} word layout and deserializer framing states.
package radioberry_pkg;

  localparam int TX_IQ_W    = 32;
  localparam int TX_NIBBLES = 8;

  typedef struct packed {
    logic [15:0] i;
    logic [15:0] q;
  } iq_word_t;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } deser_state_t;

endpackage

// File: rtl/radioberry_sync_edge.sv
// Synchronizes an async strobe plus its data bus and emits a registered one-cycle rise pulse.
// Latency: STAGES+1 clk from pin edge to rise/dat_q; no backpressure, every edge is reported.
module radioberry_sync_edge #(
  parameter int STAGES = 2,
  parameter int W      = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         strobe,
  input  logic [W-1:0] data,
  output logic         rise,
  output logic [W-1:0] dat_q
);

  logic [STAGES-1:0]        clk_sync;
  logic [STAGES-1:0][W-1:0] dat_sync;
  logic                     clk_d;
  logic                     edge_now;

  // Data travels through the same depth as the strobe so both arrive aligned.
  assign edge_now = clk_sync[STAGES-1] & ~clk_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= '0;
      dat_sync <= '0;
      clk_d    <= 1'b0;
      rise     <= 1'b0;
      dat_q    <= '0;
    end else begin
      clk_sync <= {clk_sync[STAGES-2:0], strobe};
      dat_sync <= {dat_sync[STAGES-2:0], data};
      clk_d    <= clk_sync[STAGES-1];
      rise     <= edge_now;
      if (edge_now) dat_q <= dat_sync[STAGES-1];
    end
  end

endmodule

// File: rtl/radioberry_tx_iq_deser.sv
// Assembles Pi 4-bit TX IQ nibbles into {I,Q} words on a valid/ready stream with idle re-framing.
// Latency: SYNC_STAGES+2 clk from the last nibble pin edge to iq_valid; 1-deep output register,
// words completing while the held word is stalled are dropped and counted.
module radioberry_tx_iq_deser
  import radioberry_pkg::*;
#(
  parameter int NIBBLES      = TX_NIBBLES,
  parameter int SYNC_STAGES  = 2,
  parameter int IDLE_TIMEOUT = 64,
  parameter int OVF_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pi_tx_clk,
  input  logic [3:0]           pi_tx_data,
  input  logic                 tx_enable,
  output logic [4*NIBBLES-1:0] iq_data,
  output logic                 iq_valid,
  input  logic                 iq_ready,
  output logic                 overflow,
  output logic [OVF_W-1:0]     overflow_cnt,
  output logic                 framing_err
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);

  logic         rise;
  logic [3:0]   nib;
  deser_state_t state;
  logic [CW-1:0] nib_cnt;
  logic [W-1:0]  sr;
  logic [TW-1:0] idle_tmr;

  logic         take;
  logic         word_done;
  logic         timeout;
  logic [W-1:0] sr_next;

  radioberry_sync_edge #(
    .STAGES (SYNC_STAGES),
    .W      (4)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .strobe (pi_tx_clk),
    .data   (pi_tx_data),
    .rise   (rise),
    .dat_q  (nib)
  );

  assign take      = rise & tx_enable;
  assign word_done = take & (nib_cnt == CW'(NIBBLES - 1));
  assign sr_next   = {sr[W-5:0], nib};
  // A rise in the same cycle always wins over the timeout.
  assign timeout   = ~rise & (idle_tmr == TW'(IDLE_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      nib_cnt     <= '0;
      sr          <= '0;
      idle_tmr    <= '0;
      framing_err <= 1'b0;
    end else begin
      framing_err <= 1'b0;
      if (rise)                               idle_tmr <= '0;
      else if (idle_tmr != TW'(IDLE_TIMEOUT)) idle_tmr <= idle_tmr + TW'(1);

      if (!tx_enable) begin
        state   <= ST_IDLE;
        nib_cnt <= '0;
        sr      <= '0;
      end else if (take) begin
        state   <= ST_COLLECT;
        sr      <= sr_next;
        nib_cnt <= word_done ? '0 : nib_cnt + CW'(1);
      end else if (timeout && state == ST_COLLECT) begin
        state       <= ST_IDLE;
        nib_cnt     <= '0;
        sr          <= '0;
        framing_err <= (nib_cnt != '0);
      end
    end
  end

  // Output register is deliberately independent of tx_enable so a held word still drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iq_data      <= '0;
      iq_valid     <= 1'b0;
      overflow     <= 1'b0;
      overflow_cnt <= '0;
    end else begin
      overflow <= 1'b0;
      if (word_done) begin
        if (!iq_valid || iq_ready) begin
          iq_data  <= sr_next;
          iq_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
          if (overflow_cnt != '1) overflow_cnt <= overflow_cnt + OVF_W'(1);
        end
      end else if (iq_valid && iq_ready) begin
        iq_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_radioberry_tx_iq_deser.sv
// Randomized nibble stream against a concatenate-nibbles model; checks framing, backpressure, drops.
module tb_radioberry_tx_iq_deser;
  import radioberry_pkg::*;

  localparam int OVF_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pi_tx_clk = 1'b0;
  logic [3:0]       pi_tx_data = 4'h0;
  logic             tx_enable = 1'b0;
  logic [31:0]      iq_data;
  logic             iq_valid;
  logic             iq_ready = 1'b1;
  logic             overflow;
  logic [OVF_W-1:0] overflow_cnt;
  logic             framing_err;

  int checks = 0;
  int failures = 0;
  int ovf_pulses = 0;
  int err_pulses = 0;
  logic [31:0] acc_q[$];

  always #5 clk = ~clk;

  radioberry_tx_iq_deser #(
    .NIBBLES      (8),
    .SYNC_STAGES  (2),
    .IDLE_TIMEOUT (64),
    .OVF_W        (OVF_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pi_tx_clk    (pi_tx_clk),
    .pi_tx_data   (pi_tx_data),
    .tx_enable    (tx_enable),
    .iq_data      (iq_data),
    .iq_valid     (iq_valid),
    .iq_ready     (iq_ready),
    .overflow     (overflow),
    .overflow_cnt (overflow_cnt),
    .framing_err  (framing_err)
  );

  always @(posedge clk) begin
    if (rst_n) begin
      if (iq_valid && iq_ready) acc_q.push_back(iq_data);
      if (overflow) ovf_pulses++;
      if (framing_err) err_pulses++;
    end
  end

  // One nibble every 8 clk: data set, strobe rises 2 clk later, falls 4 clk after that.
  task automatic send_nib(input logic [3:0] n);
    @(negedge clk) pi_tx_data = n;
    repeat (2) @(negedge clk);
    pi_tx_clk = 1'b1;
    repeat (4) @(negedge clk);
    pi_tx_clk = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_word(output logic [31:0] w);
    logic [3:0] n;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      n = 4'($urandom_range(15, 0));
      w = {w[27:0], n};
      send_nib(n);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tx_enable = 1'b1;
    iq_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (iq_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", iq_valid); end
    checks++; if (iq_data !== 32'h0) begin failures++; $display("FAIL reset_data: got %h want 0", iq_data); end
    checks++; if (overflow_cnt !== '0) begin failures++; $display("FAIL reset_ovf_cnt: got %0d want 0", overflow_cnt); end
    checks++; if ({overflow, framing_err} !== 2'b00) begin failures++; $display("FAIL reset_pulses: got %b want 00", {overflow, framing_err}); end
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_word;
    iq_ready = 1'b1;
    acc_q.delete();
    for (int i = 1; i <= 7; i++) send_nib(4'(i));
    @(negedge clk) pi_tx_data = 4'h8;
    repeat (2) @(negedge clk);
    pi_tx_clk = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (iq_valid !== 1'b0) begin failures++; $display("FAIL latency_early: got valid=%b want 0", iq_valid); end
    @(posedge clk); #1;
    checks++; if (iq_valid !== 1'b1) begin failures++; $display("FAIL latency_on_time: got valid=%b want 1", iq_valid); end
    checks++; if (iq_data !== 32'h12345678) begin failures++; $display("FAIL word_12345678: got %h want 12345678", iq_data); end
    @(posedge clk); #1;
    checks++; if (iq_valid !== 1'b0) begin failures++; $display("FAIL valid_one_cycle: got %b want 0", iq_valid); end
    @(negedge clk) pi_tx_clk = 1'b0;
    @(negedge clk);
    checks++; if (acc_q.size() != 1) begin failures++; $display("FAIL single_accept_count: got %0d want 1", acc_q.size()); end
  endtask

  task automatic test_random_words;
    logic [31:0] exp_q[$];
    logic [31:0] w;
    acc_q.delete();
    for (int k = 0; k < 4; k++) begin
      send_word(w);
      exp_q.push_back(w);
    end
    checks++; if (acc_q.size() != 4) begin failures++; $display("FAIL random_count: got %0d want 4", acc_q.size()); end
    for (int k = 0; k < 4 && k < acc_q.size(); k++) begin
      checks++; if (acc_q[k] !== exp_q[k]) begin failures++; $display("FAIL random_word%0d: got %h want %h", k, acc_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] w1, w2;
    int p0;
    acc_q.delete();
    p0 = ovf_pulses;
    @(negedge clk) iq_ready = 1'b0;
    send_word(w1);
    send_word(w2);
    checks++; if (iq_valid !== 1'b1 || iq_data !== w1) begin failures++; $display("FAIL bp_held: got %b/%h want 1/%h", iq_valid, iq_data, w1); end
    checks++; if (ovf_pulses - p0 != 1) begin failures++; $display("FAIL bp_ovf_pulse: got %0d want 1", ovf_pulses - p0); end
    checks++; if (overflow_cnt !== OVF_W'(1)) begin failures++; $display("FAIL bp_ovf_cnt: got %0d want 1", overflow_cnt); end
    @(negedge clk) iq_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (iq_valid !== 1'b0) begin failures++; $display("FAIL bp_drain: got valid=%b want 0", iq_valid); end
    checks++; if (acc_q.size() != 1 || acc_q[0] !== w1) begin failures++; $display("FAIL bp_accepted: got n=%0d want w1=%h", acc_q.size(), w1); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] w1, w2;
    logic [3:0] n;
    int p0;
    acc_q.delete();
    p0 = ovf_pulses;
    @(negedge clk) iq_ready = 1'b0;
    send_word(w1);
    w2 = '0;
    for (int i = 0; i < 7; i++) begin
      n = 4'($urandom_range(15, 0));
      w2 = {w2[27:0], n};
      send_nib(n);
    end
    n = 4'($urandom_range(15, 0));
    w2 = {w2[27:0], n};
    @(negedge clk) pi_tx_data = n;
    repeat (2) @(negedge clk);
    pi_tx_clk = 1'b1;
    repeat (3) @(negedge clk);
    iq_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (iq_valid !== 1'b1 || iq_data !== w2) begin failures++; $display("FAIL b2b_second: got %b/%h want 1/%h", iq_valid, iq_data, w2); end
    checks++; if (ovf_pulses != p0) begin failures++; $display("FAIL b2b_no_drop: got %0d drops want 0", ovf_pulses - p0); end
    @(negedge clk) pi_tx_clk = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (acc_q.size() != 2 || acc_q[0] !== w1 || acc_q[acc_q.size()-1] !== w2) begin
      failures++; $display("FAIL b2b_order: got n=%0d want %h then %h", acc_q.size(), w1, w2);
    end
  endtask

  task automatic test_framing;
    logic [31:0] w;
    iq_word_t exp_w;
    int e0;
    acc_q.delete();
    e0 = err_pulses;
    for (int i = 0; i < 3; i++) send_nib(4'($urandom_range(15, 0)));
    repeat (50) @(negedge clk);
    checks++; if (err_pulses != e0) begin failures++; $display("FAIL frame_early_err: got %0d want 0", err_pulses - e0); end
    repeat (30) @(negedge clk);
    checks++; if (err_pulses - e0 != 1) begin failures++; $display("FAIL frame_err_pulse: got %0d want 1", err_pulses - e0); end
    send_word(w);
    exp_w = w;
    checks++; if (acc_q.size() != 1 || acc_q[0] !== exp_w) begin
      failures++; $display("FAIL frame_realign: got n=%0d want I=%h Q=%h", acc_q.size(), exp_w.i, exp_w.q);
    end
    repeat (80) @(negedge clk);
    checks++; if (err_pulses - e0 != 1) begin failures++; $display("FAIL frame_idle_clean: got %0d errs want 1", err_pulses - e0); end
  endtask

  task automatic test_tx_disable;
    int e0;
    acc_q.delete();
    e0 = err_pulses;
    for (int i = 0; i < 4; i++) send_nib(4'($urandom_range(15, 0)));
    @(negedge clk) tx_enable = 1'b0;
    send_nib(4'($urandom_range(15, 0)));
    repeat (80) @(negedge clk);
    checks++; if (acc_q.size() != 0 || err_pulses != e0) begin
      failures++; $display("FAIL disable_silent: got words=%0d errs=%0d want 0/0", acc_q.size(), err_pulses - e0);
    end
    tx_enable = 1'b1;
    for (int i = 15; i >= 8; i--) send_nib(4'(i));
    checks++; if (acc_q.size() != 1 || acc_q[0] !== 32'hFEDCBA98) begin failures++; $display("FAIL disable_reenable: got n=%0d want FEDCBA98", acc_q.size()); end
  endtask

  task automatic test_reset_midword;
    logic [31:0] w;
    @(negedge clk) iq_ready = 1'b0;
    send_word(w);
    send_word(w);
    for (int i = 0; i < 3; i++) send_nib(4'($urandom_range(15, 0)));
    @(negedge clk) rst_n = 1'b0;
    #1;
    checks++; if ({iq_valid, overflow, framing_err} !== 3'b000 || overflow_cnt !== '0 || iq_data !== 32'h0) begin
      failures++; $display("FAIL rst_immediate: got v=%b cnt=%0d d=%h want all 0", iq_valid, overflow_cnt, iq_data);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if ({iq_valid, overflow, framing_err} !== 3'b000 || overflow_cnt !== '0) begin
      failures++; $display("FAIL rst_release: got v=%b cnt=%0d want 0", iq_valid, overflow_cnt);
    end
    @(negedge clk) iq_ready = 1'b1;
    acc_q.delete();
    send_word(w);
    checks++; if (acc_q.size() != 1 || acc_q[0] !== w) begin failures++; $display("FAIL rst_realign: got n=%0d want %h", acc_q.size(), w); end
  endtask

  task automatic test_ovf_saturate;
    logic [31:0] w1, w;
    int p0;
    int drops;
    drops = (1 << OVF_W) + 3;
    p0 = ovf_pulses;
    @(negedge clk) iq_ready = 1'b0;
    send_word(w1);
    for (int k = 0; k < drops; k++) send_word(w);
    checks++; if (overflow_cnt !== {OVF_W{1'b1}}) begin failures++; $display("FAIL ovf_saturate: got %0d want %0d", overflow_cnt, (1 << OVF_W) - 1); end
    checks++; if (ovf_pulses - p0 != drops) begin failures++; $display("FAIL ovf_pulses: got %0d want %0d", ovf_pulses - p0, drops); end
    checks++; if (iq_data !== w1) begin failures++; $display("FAIL ovf_held_word: got %h want %h", iq_data, w1); end
    @(negedge clk) iq_ready = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_random_words();
    test_backpressure();
    test_back_to_back();
    test_framing();
    test_tx_disable();
    test_reset_midword();
    test_ovf_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
